// File: rtl/a_run_ctrl_if.sv
// Host command and clock-generator signal bundle for a_run_ctrl.
// slave: the sequencer side; master: host / clock-generator side.
interface a_run_ctrl_if #(parameter int CNT_W = 32);
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [1:0]       cmd_op_i;
    logic [CNT_W-1:0] cmd_arg_i;
    logic             cycle_run_verif_i;
    logic             prog_o;
    logic             prog_w_o;
    logic [15:0]      prog_data_o;
    logic             prog_dv_o;
    logic             start_run_verif_o;
    logic             run_verif_o;
    logic             mode_pas_a_pas_o;
    logic             busy_o;
    logic             done_o;
    logic             stopped_o;
    logic             err_o;
    logic [CNT_W-1:0] cycles_done_o;

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_arg_i, cycle_run_verif_i,
        output cmd_ready_o, prog_o, prog_w_o, prog_data_o, prog_dv_o,
               start_run_verif_o, run_verif_o, mode_pas_a_pas_o, busy_o,
               done_o, stopped_o, err_o, cycles_done_o
    );

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_arg_i, cycle_run_verif_i,
        input  cmd_ready_o, prog_o, prog_w_o, prog_data_o, prog_dv_o,
               start_run_verif_o, run_verif_o, mode_pas_a_pas_o, busy_o,
               done_o, stopped_o, err_o, cycles_done_o
    );
endinterface

// File: rtl/a_run_ctrl.sv
// Run/step sequencer for the user-clock generator: divider programming, N-cycle runs, single step.
// Optional watchdog on RUN/STEP enabled by defining RUN_TIMEOUT_EN.
module a_run_ctrl #(
    parameter int CNT_W       = 32,
    parameter int DRAIN_CYC   = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk_ref,
    input  logic        rst,
    a_run_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PROG, ARM, RUN, STEP, DRAIN} state_t;

    localparam logic [1:0] OP_PROG = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_STOP = 2'd3;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d, cnt_q, cnt_d, cnt_inc;
    logic [15:0]      div_q, div_d;
    logic [3:0]       drain_q, drain_d;
    logic             stopped_q, stopped_d;
    logic             done_q, done_d, err_q, err_d;
    logic             step_first_q;
    logic             ready;
    logic             pulse, stop_req;

`ifdef RUN_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q, wd_d;

    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) wd_q <= '0;
        else     wd_q <= wd_d;
    end
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT_CYC);
`endif

    assign pulse    = bus.cycle_run_verif_i;
    assign stop_req = bus.cmd_valid_i && (bus.cmd_op_i == OP_STOP);
    // Saturating increment: the count never wraps back to zero.
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        drain_d   = '0;
        stopped_d = stopped_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        ready     = 1'b0;
`ifdef RUN_TIMEOUT_EN
        wd_d      = '0;
`endif
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.cmd_valid_i) begin
                    case (bus.cmd_op_i)
                        OP_PROG: begin
                            if (bus.cmd_arg_i[15:0] == 16'd0) err_d = 1'b1;
                            else begin
                                div_d   = bus.cmd_arg_i[15:0];
                                state_d = PROG;
                            end
                        end
                        OP_RUN: begin
                            if (bus.cmd_arg_i == '0) err_d = 1'b1;
                            else begin
                                n_d       = bus.cmd_arg_i;
                                cnt_d     = '0;
                                stopped_d = 1'b0;
                                state_d   = ARM;
                            end
                        end
                        OP_STEP: begin
                            cnt_d     = '0;
                            stopped_d = 1'b0;
                            state_d   = STEP;
                        end
                        default: ;
                    endcase
                end
            end
            PROG: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            ARM: state_d = RUN;
            RUN, STEP: begin
                ready = (bus.cmd_op_i == OP_STOP);
                // A final pulse outranks a coincident STOP: the run completed normally.
                if (pulse) begin
                    cnt_d = cnt_inc;
                    if (state_q == STEP || cnt_inc == n_q) state_d = DRAIN;
                end
                if (state_d != DRAIN && stop_req) begin
                    stopped_d = 1'b1;
                    state_d   = DRAIN;
                end
`ifdef RUN_TIMEOUT_EN
                if (state_d != DRAIN) begin
                    if (pulse) wd_d = '0;
                    else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                        err_d     = 1'b1;
                        stopped_d = 1'b1;
                        state_d   = DRAIN;
                    end else wd_d = wd_q + 1'b1;
                end
`endif
            end
            DRAIN: begin
                drain_d = drain_q + 4'd1;
                if (drain_q == 4'(DRAIN_CYC - 1)) begin
                    drain_d = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            n_q          <= '0;
            cnt_q        <= '0;
            div_q        <= '0;
            drain_q      <= '0;
            stopped_q    <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            step_first_q <= 1'b0;
        end else begin
            n_q          <= n_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            drain_q      <= drain_d;
            stopped_q    <= stopped_d;
            done_q       <= done_d;
            err_q        <= err_d;
            step_first_q <= (state_d == STEP) && (state_q != STEP);
        end
    end

    assign bus.cmd_ready_o       = ready;
    assign bus.busy_o            = (state_q != IDLE);
    assign bus.prog_o            = (state_q == PROG);
    assign bus.prog_w_o          = (state_q == PROG);
    assign bus.prog_dv_o         = (state_q == PROG) || (state_q == ARM);
    assign bus.prog_data_o       = div_q;
    assign bus.start_run_verif_o = (state_q == ARM) || (state_q == RUN);
    assign bus.run_verif_o       = (state_q == ARM) || (state_q == RUN);
    assign bus.mode_pas_a_pas_o  = (state_q == STEP) && step_first_q;
    assign bus.done_o            = done_q;
    assign bus.err_o             = err_q;
    assign bus.stopped_o         = stopped_q;
    assign bus.cycles_done_o     = cnt_q;
endmodule

// File: doc/a_run_ctrl.md
Name: a_run_ctrl

Overview:
Run/step sequencer for the user-clock generator in the emulation control path. It takes host commands, programs the clock divider through the generator's register interface, and drives the start, run and step-mode strobes. It counts user cycles reported by the generator and ends a run after exactly N cycles or on a stop request. It sits between the host command decoder and the clock generator / stimulus / trace blocks.

Parameters:
CNT_W, 32, width of the run-length argument and of the cycle counter
DRAIN_CYC, 4, clk_ref cycles held in DRAIN with run deasserted before done (range 1..15)
TIMEOUT_CYC, 65535, watchdog limit in clk_ref cycles; used only with RUN_TIMEOUT_EN

Ports:
clk_ref  in  1  reference clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-high
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_op_i  in  2  00 PROG_DIV, 01 RUN, 10 STEP, 11 STOP
cmd_arg_i  in  CNT_W  PROG_DIV: divider word in [15:0]; RUN: cycle count N
cycle_run_verif_i  in  1  one-clk_ref pulse per user cycle, from the clock generator
prog_o  out  1  divider register select
prog_w_o  out  1  write strobe qualifier
prog_data_o  out  16  divider word
prog_dv_o  out  1  data valid
start_run_verif_o  out  1  start qualifier
run_verif_o  out  1  run enable
mode_pas_a_pas_o  out  1  step-mode request
busy_o  out  1  state != IDLE
done_o  out  1  1-cycle completion pulse
stopped_o  out  1  last run ended by STOP or timeout; held until next accepted RUN/STEP
err_o  out  1  1-cycle error pulse
cycles_done_o  out  CNT_W  user cycles counted in the current/last run

Behaviour:
- Reset: every output is 0, except cmd_ready_o = 1. State is IDLE. Counter and argument registers are cleared.
- States: IDLE, PROG, ARM, RUN, STEP, DRAIN.
- IDLE: cmd_ready_o = 1.
  - PROG_DIV with arg[15:0] != 0 goes to PROG.
  - PROG_DIV with arg[15:0] == 0: err_o pulse, stays in IDLE, no write.
  - RUN with N == 0: err_o pulse, stays in IDLE.
  - RUN with N != 0: latch N, clear cycles_done_o and stopped_o, go to ARM.
  - STEP: clear cycles_done_o and stopped_o, go to STEP.
  - STOP in IDLE: accepted and ignored, no pulse.
- PROG: exactly one cycle with prog_o = prog_w_o = prog_dv_o = 1 and prog_data_o = latched word. Next cycle: done_o pulse, return to IDLE. prog_data_o holds its value afterwards.
- ARM: one cycle with start_run_verif_o = run_verif_o = prog_dv_o = 1 and prog_o = 0; then RUN.
- RUN: start_run_verif_o = run_verif_o = 1.
  - Each cycle_run_verif_i pulse increments cycles_done_o.
  - When the increment makes the count equal N, both strobes drop on the next cycle and the FSM enters DRAIN.
  - cmd_ready_o = 1 only for STOP. STOP goes to DRAIN with stopped_o = 1.
  - STOP in the same cycle as the final pulse counts as normal completion: count = N, stopped_o = 0.
- STEP: first cycle drives mode_pas_a_pas_o = 1, then deasserts it and waits.
  - First cycle_run_verif_i pulse: cycles_done_o = 1, go to DRAIN.
  - A STOP while waiting goes to DRAIN with stopped_o = 1.
- DRAIN: all strobes 0 for DRAIN_CYC cycles, then done_o pulse and return to IDLE. Pulses arriving in DRAIN are not counted.
- Counter width rule: cycles_done_o saturates at all-ones and never wraps.
- cmd_ready_o is 0 in PROG, ARM and DRAIN, and 0 for non-STOP opcodes in RUN/STEP. Non-STOP commands there are held by the requester, not dropped.
- Reset asserted mid-operation: outputs clear immediately (async); run_verif_o drops without DRAIN; no done_o pulse.

Optional Feature:
RUN_TIMEOUT_EN:
- Defined: a watchdog counts clk_ref cycles in RUN/STEP since the last cycle_run_verif_i pulse (or since entry to the state). Reaching TIMEOUT_CYC gives an err_o pulse, stopped_o = 1, and a move to DRAIN, which ends with done_o as normal.
- Undefined: no watchdog logic; RUN/STEP wait indefinitely for pulses or STOP.

Test Plan:
- Reset, then PROG_DIV arg=16'h0004 -> one cycle prog_o=prog_w_o=prog_dv_o=1 with prog_data_o=0x0004; done_o 1 cycle later; err_o=0.
- RUN N=5 with pulses every 8 clk_ref -> run_verif_o high from ARM until the cycle after pulse 5; DRAIN_CYC=4 idle cycles; done_o; cycles_done_o=5; stopped_o=0.
- RUN N=100, STOP after pulse 3 -> DRAIN, cycles_done_o=3, stopped_o=1, done_o; separately, STOP coincident with pulse N=2 -> cycles_done_o=2, stopped_o=0.
- STEP -> mode_pas_a_pas_o high exactly 1 cycle; after one pulse cycles_done_o=1 and done_o; PROG_DIV offered during STEP is held (cmd_ready_o=0) and accepted after return to IDLE.
- Errors: PROG_DIV arg=0 and RUN N=0 -> err_o pulse each, busy_o stays 0, no strobes toggle.
- RUN_TIMEOUT_EN defined, TIMEOUT_CYC=16, RUN N=3 with no pulses -> err_o on cycle 16, stopped_o=1, done_o after DRAIN; reset asserted mid-RUN -> run_verif_o=0 asynchronously and no done_o.
